// File: rtl/fifo_reader_pkg.sv
// Shared sizing for the fifo_reader read adapter and its output buffer.
// The buffer is 3 deep, so pointers and the occupancy count share one 2-bit type.
package fifo_reader_pkg;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;
    // A read may issue only while buffered plus in-flight words stay at or below this.
    localparam int unsigned ISSUE_MAX = BUF_DEPTH - 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Circular pointer advance: 0 -> 1 -> 2 -> 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_reader_rd_skid_buf.sv
// 3-entry circular buffer that absorbs the FIFO's one-cycle read latency.
// Clear has priority over push and pop and returns both pointers to slot 0.
module rd_skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [PTR_W-1:0] count,
    output logic [W-1:0]     head
);

    logic [W-1:0] mem [BUF_DEPTH];
    ptr_t         rd_ptr;
    ptr_t         wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + PTR_W'(push) - PTR_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO (registered read, empty flag, rd_en pop) into a
// valid/ready stream, issuing reads ahead so the stream runs without bubbles.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [W-1:0]     fifo_rd_data,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic [CNT_W-1:0] xfer_count
);

    logic             inflight;
    logic             pop;
    logic [PTR_W-1:0] count;
    logic [PTR_W:0]   occupancy;

    // Reserve a slot for every word already requested so the buffer never overflows.
    assign occupancy  = {1'b0, count} + {{PTR_W{1'b0}}, inflight};
    assign fifo_rd_en = !rst && !flush && !fifo_empty
                        && (occupancy <= (PTR_W + 1)'(ISSUE_MAX));

    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

    rd_skid_buf #(
        .W (W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .count     (count),
        .head      (m_data)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural FIFO feeds the DUT, a scoreboard queue
// holds the words the stream must carry, and a negedge monitor checks them.
module tb_fifo_reader;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [W-1:0]     fifo_rd_data = '0;
    logic             flush = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [W-1:0]     m_data;
    logic [CNT_W-1:0] xfer_count;

    fifo_reader #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .xfer_count   (xfer_count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read, never reset, so it keeps its head across DUT resets.
    logic [W-1:0] fifo_mem [1024];
    int           fifo_head = 0;
    int           fifo_tail = 0;
    assign fifo_empty = (fifo_head == fifo_tail);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fifo_mem[fifo_head];
            fifo_head    <= fifo_head + 1;
        end
    end

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    int           accepted  = 0;
    int           discarded = 0;
    logic [CNT_W-1:0] xfer_exp = '0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] v);
        fifo_mem[fifo_tail] = v;
        fifo_tail++;
        exp_q.push_back(v);
    endtask

    // Words already pulled out of the FIFO but not delivered are lost on flush/reset.
    task automatic discard_lost(output int lost);
        lost = fifo_head - accepted - discarded;
        for (int i = 0; i < lost; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        discarded += lost;
    endtask

    task automatic drain(input int max_cycles);
        m_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !m_valid && fifo_empty) break;
            step();
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            xfer_exp = '0;
            check("rst_m_valid", m_valid, 0);
            check("rst_rd_en", fifo_rd_en, 0);
        end else begin
            if (fifo_empty || flush) check("rd_en_gated", fifo_rd_en, 0);
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, data_prev);
            end
        end
        check("xfer_count", xfer_count, xfer_exp);
        if (!rst && m_valid && m_ready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
            accepted++;
            xfer_exp = xfer_exp + 1'b1;
        end
        stall_prev = !rst && !flush && m_valid && !m_ready;
        data_prev  = m_data;
    end

    initial begin
        int start;
        int lost;
        int pushed;

        // Reset held with data waiting, then streaming of 0x10..0x17.
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_xfer", xfer_count, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_rd_en", fifo_rd_en, 1);
        check("lat_valid0", m_valid, 0);
        @(negedge clk);
        check("lat_valid1", m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stream_valid", m_valid, 1);
        end
        step();
        check("stream_xfer", xfer_count, 8);
        check("stream_done", m_valid, 0);

        // Backpressure: three reads fill the buffer, head held until ready.
        step();
        m_ready = 1'b0;
        start = fifo_head;
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        repeat (10) step();
        check("bp_reads", fifo_head - start, 3);
        check("bp_head", m_data, 8'h10);
        check("bp_valid", m_valid, 1);
        drain(100);

        // Random ready over a 100-word counting pattern with sporadic pushes.
        pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pushed == 100 && exp_q.size() == 0 && !m_valid) break;
            if (pushed < 100 && $urandom_range(0, 1) == 1) begin
                push_word(8'(pushed));
                pushed++;
            end
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        check("rand_pushed", pushed, 100);
        drain(200);

        // Flush while the second read is in flight; the read it would have issued is blocked.
        step();
        m_ready = 1'b0;
        start = fifo_head;
        for (int i = 0; i < 8; i++) push_word(8'(8'h20 + i));
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", m_valid, 0);
        discard_lost(lost);
        check("flush_lost", lost, 2);
        check("flush_resume", exp_q[0], 8'h22);
        step();
        drain(100);

        // Asynchronous reset between edges during streaming.
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(8'(8'h40 + i));
        repeat (6) step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_xfer", xfer_count, 0);
        discard_lost(lost);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("arst_resume_rd", fifo_rd_en, 1);
        step();
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
